classify_sequencer: RTL and testbench

CLASSIFY_SEQUENCER -- requirements
Module: classify_sequencer

---
 rtl/classify_sequencer.sv | 112 +++++++++++
 tb/tb_classify_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/classify_sequencer.sv
// Request/response sequencer that starts one network run per request and captures the class/balance after a fixed wait.
// Optional CLASSIFY_SEQ_CLASS_CHECK_EN maps net_class 00/11 at capture to the error code 11.
module classify_sequencer #(
    parameter int WIDTH      = 8,
    parameter int HEIGHT     = 7,
    parameter int SETTLE     = 2,
    parameter int RUN_CYCLES = HEIGHT * (2 ** (WIDTH + 2)),
    parameter int BAL_W      = $clog2(HEIGHT * (2 ** WIDTH - 1) + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [HEIGHT-1:0] req_pixels,
    output logic [HEIGHT-1:0] net_pixels,
    output logic              net_start,
    input  logic [1:0]        net_class,
    input  logic [BAL_W-1:0]  net_balance,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_class,
    output logic [BAL_W-1:0]  rsp_balance,
    output logic              busy
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // req_ready is only high in IDLE, rsp_valid is only high in RESP and holds until rsp_ready.
    localparam int WAIT  = RUN_CYCLES + SETTLE;
    localparam int CNT_W = $clog2(WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             capture;
    logic             rsp_done;
    logic [1:0]       cap_class;

    assign accept   = req_valid && req_ready;
    assign capture  = (state == ST_RUN) && (cnt == CNT_LAST);
    assign rsp_done = rsp_valid && rsp_ready;

`ifdef CLASSIFY_SEQ_CLASS_CHECK_EN
    assign cap_class = ((net_class == 2'b00) || (net_class == 2'b11)) ? 2'b11 : net_class;
`else
    assign cap_class = net_class;
`endif

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (accept)   next_state = ST_START;
            ST_START: next_state = ST_RUN;
            ST_RUN:   if (capture)  next_state = ST_RESP;
            ST_RESP:  if (rsp_done) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Flag outputs are registered from next_state so they never glitch on multi-bit state changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            req_ready <= 1'b0;
            net_start <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= next_state;
            req_ready <= (next_state == ST_IDLE);
            net_start <= (next_state == ST_START);
            busy      <= (next_state != ST_IDLE);
        end
    end

    // Counter stops at WAIT-1, so it cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == ST_RUN) begin
            if (!capture) cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            net_pixels <= '0;
        end else if (accept) begin
            net_pixels <= req_pixels;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid   <= 1'b0;
            rsp_class   <= 2'b00;
            rsp_balance <= '0;
        end else if (capture) begin
            rsp_valid   <= 1'b1;
            rsp_class   <= cap_class;
            rsp_balance <= net_balance;
        end else if (rsp_done) begin
            rsp_valid   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_classify_sequencer.sv
// Bench for classify_sequencer with WIDTH=2, HEIGHT=2, SETTLE=2 (RUN_CYCLES=32, WAIT=34).
module tb_classify_sequencer;
    localparam int WIDTH      = 2;
    localparam int HEIGHT     = 2;
    localparam int SETTLE     = 2;
    localparam int RUN_CYCLES = 32;
    localparam int WAIT       = RUN_CYCLES + SETTLE;
    localparam int BAL_W      = 3;
    localparam int B2B_GAP    = WAIT + 3;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [HEIGHT-1:0] req_pixels;
    logic [HEIGHT-1:0] net_pixels;
    logic              net_start;
    logic [1:0]        net_class;
    logic [BAL_W-1:0]  net_balance;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_class;
    logic [BAL_W-1:0]  rsp_balance;
    logic              busy;

    int n_chk;
    int n_fail;
    logic mon_en;
    logic [HEIGHT-1:0] exp_pix;
    logic [BAL_W+1:0] exp_q[$];

    typedef struct {
        logic [HEIGHT-1:0] pix;
        logic [1:0]        cls;
        logic [BAL_W-1:0]  bal;
        logic [1:0]        exp_cls;
        int                hold;
        int                junk;
    } vec_t;
    vec_t vecs[5];

    classify_sequencer #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT),
        .SETTLE(SETTLE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_pixels (req_pixels),
        .net_pixels (net_pixels),
        .net_start  (net_start),
        .net_class  (net_class),
        .net_balance(net_balance),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_class  (rsp_class),
        .rsp_balance(rsp_balance),
        .busy       (busy)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: class seen at the capture edge, optionally mapped to the error code.
    function automatic logic [1:0] model_class(input logic [1:0] c);
`ifdef CLASSIFY_SEQ_CLASS_CHECK_EN
        if (c == 2'b00 || c == 2'b11) return 2'b11;
`endif
        return c;
    endfunction

    always @(negedge clk) begin
        if (mon_en) chk("net_pixels_stable", 32'(net_pixels), 32'(exp_pix));
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_net_start"}, 32'(net_start), 32'd0);
        chk({tag, "_net_pixels"}, 32'(net_pixels), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_class"}, 32'(rsp_class), 32'd0);
        chk({tag, "_rsp_balance"}, 32'(rsp_balance), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("req_ready_before_edge", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("req_ready_after_reset", 32'(req_ready), 32'd1);
    endtask

    task automatic drive_junk(input int mode, input int k);
        case (mode)
            0: begin net_class = 2'b00; net_balance = '0; end
            1: begin
                net_class   = (k % 2 == 1) ? 2'b01 : 2'b00;
                net_balance = BAL_W'($urandom_range(0, 7));
            end
            default: begin
                net_class   = 2'($urandom_range(0, 3));
                net_balance = BAL_W'($urandom_range(0, 7));
            end
        endcase
    endtask

    task automatic wait_ready(output bit ok);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 100);
        chk("req_ready_wait", 32'(ok), 32'd1);
    endtask

    // Driver: one full request/response transaction, starting and ending at a falling edge.
    task automatic do_req(input logic [HEIGHT-1:0] pix, input logic [1:0] cls,
                          input logic [BAL_W-1:0] bal, input logic [1:0] exp_cls,
                          input int hold, input int junk);
        bit ok;
        logic [BAL_W+1:0] exp_rsp;
        logic [1:0] hold_cls;
        logic [BAL_W-1:0] hold_bal;
        wait_ready(ok);
        if (!ok) return;
        req_valid  = 1'b1;
        req_pixels = pix;
        @(posedge clk);
        exp_pix = pix;
        @(negedge clk);
        req_valid = 1'b0;
        chk("net_start_pulse", 32'(net_start), 32'd1);
        chk("busy_start", 32'(busy), 32'd1);
        chk("req_ready_start", 32'(req_ready), 32'd0);
        exp_q.push_back({exp_cls, bal});
        for (int k = 0; k <= WAIT; k++) begin
            if (k > 0) begin
                @(negedge clk);
                chk("net_start_low", 32'(net_start), 32'd0);
            end
            chk("rsp_valid_early", 32'(rsp_valid), 32'd0);
            if (k == WAIT) begin
                net_class   = cls;
                net_balance = bal;
            end else begin
                drive_junk(junk, k);
            end
            if (junk == 2 && k < WAIT - 2) begin
                req_valid  = 1'($urandom_range(0, 1));
                req_pixels = HEIGHT'($urandom_range(0, 3));
            end else begin
                req_valid = 1'b0;
            end
        end
        @(negedge clk);
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        exp_rsp  = exp_q.pop_front();
        hold_cls = exp_rsp[BAL_W+1:BAL_W];
        hold_bal = exp_rsp[BAL_W-1:0];
        chk("rsp_valid_latency", 32'(rsp_valid), 32'd1);
        chk("rsp_class", 32'(rsp_class), 32'(hold_cls));
        chk("rsp_balance", 32'(rsp_balance), 32'(hold_bal));
        chk("req_ready_resp", 32'(req_ready), 32'd0);
        drive_junk(2, 0);
        for (int h = 0; h < hold; h++) begin
            req_valid  = 1'($urandom_range(0, 1));
            req_pixels = HEIGHT'($urandom_range(0, 3));
            @(negedge clk);
            chk("rsp_valid_hold", 32'(rsp_valid), 32'd1);
            chk("rsp_class_hold", 32'(rsp_class), 32'(hold_cls));
            chk("rsp_balance_hold", 32'(rsp_balance), 32'(hold_bal));
            chk("req_ready_hold", 32'(req_ready), 32'd0);
            chk("busy_hold", 32'(busy), 32'd1);
            drive_junk(2, 0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        chk("req_ready_after_hs", 32'(req_ready), 32'd1);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        bit ok;
        int last;
        int n_acc;
        int n;
        logic accepting;

        vecs[0] = '{pix: 2'b11, cls: 2'b01, bal: 3'd5, exp_cls: 2'b01, hold: 0,  junk: 0};
        vecs[1] = '{pix: 2'b01, cls: 2'b10, bal: 3'd3, exp_cls: 2'b10, hold: 10, junk: 1};
`ifdef CLASSIFY_SEQ_CLASS_CHECK_EN
        vecs[2] = '{pix: 2'b10, cls: 2'b00, bal: 3'd7, exp_cls: 2'b11, hold: 2,  junk: 2};
`else
        vecs[2] = '{pix: 2'b10, cls: 2'b00, bal: 3'd7, exp_cls: 2'b00, hold: 2,  junk: 2};
`endif
        vecs[3] = '{pix: 2'b00, cls: 2'b11, bal: 3'd0, exp_cls: 2'b11, hold: 1,  junk: 1};
        vecs[4] = '{pix: 2'b11, cls: 2'b01, bal: 3'd6, exp_cls: 2'b01, hold: 3,  junk: 2};

        n_chk = 0; n_fail = 0; mon_en = 1'b0; exp_pix = '0;
        rst_n = 1'b0; req_valid = 1'b0; req_pixels = '0; rsp_ready = 1'b0;
        net_class = 2'b00; net_balance = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        release_reset();
        mon_en = 1'b1;

        for (int i = 0; i < 5; i++) begin
            do_req(vecs[i].pix, vecs[i].cls, vecs[i].bal, vecs[i].exp_cls, vecs[i].hold, vecs[i].junk);
        end

        // Reset in the middle of RUN (count 17) after a prior response left nonzero rsp fields.
        wait_ready(ok);
        if (ok) begin
            req_valid  = 1'b1;
            req_pixels = 2'b10;
            @(posedge clk);
            exp_pix = 2'b10;
            @(negedge clk);
            req_valid = 1'b0;
            repeat (18) @(negedge clk);
            chk("busy_mid_run", 32'(busy), 32'd1);
            #2;
            rst_n   = 1'b0;
            exp_pix = '0;
            #1;
            chk_reset_vals("mid_run_reset");
            release_reset();
            do_req(2'b01, 2'b10, 3'd2, 2'b10, 1, 0);
        end

        for (int i = 0; i < 15; i++) begin
            logic [1:0] c;
            c = 2'($urandom_range(0, 3));
            do_req(HEIGHT'($urandom_range(0, 3)), c, BAL_W'($urandom_range(0, 7)),
                   model_class(c), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        // Back-to-back requests with rsp_ready tied high.
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        last  = -1;
        n_acc = 0;
        for (int c = 0; c < 200 && n_acc < 4; c++) begin
            req_pixels = HEIGHT'($urandom_range(0, 3));
            accepting  = req_ready;
            @(posedge clk);
            if (accepting) begin
                exp_pix = req_pixels;
                if (last >= 0) chk("accept_spacing", 32'(c - last), 32'(B2B_GAP));
                last = c;
                n_acc++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("b2b_accepts", 32'(n_acc), 32'd4);
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_drain", 32'(n < 100), 32'd1);
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("final_idle_ready", 32'(req_ready), 32'd1);
        chk("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
